// File: rtl/mem_wb_skid.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_wb_skid
// Purpose  : MEM/WB pipeline stage with a valid/ready handshake and a
//            2-entry skid buffer (head + skid). A stalled write-back never
//            drops or duplicates an instruction. Supports NWB GPR
//            write-back ports, an optional HI/LO channel, synchronous flush
//            and suppression of writes to GPR r0.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            flush           - discard all buffered entries
//            in_valid/ready  - MEM-side handshake
//            in_wreg/waddr/wdata, in_whilo/hi/lo - incoming payload
//            out_valid/ready - WB-side handshake
//            out_wreg/waddr/wdata, out_whilo/hi/lo - head entry payload
//            occupancy       - number of stored entries (0..2)
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_skid #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NWB     = 1,
  parameter int HILO_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  // MEM side
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NWB-1:0]        in_wreg,
  input  logic [NWB*ADDR_W-1:0] in_waddr,
  input  logic [NWB*DATA_W-1:0] in_wdata,
  input  logic                  in_whilo,
  input  logic [DATA_W-1:0]     in_hi,
  input  logic [DATA_W-1:0]     in_lo,
  // WB side
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NWB-1:0]        out_wreg,
  output logic [NWB*ADDR_W-1:0] out_waddr,
  output logic [NWB*DATA_W-1:0] out_wdata,
  output logic                  out_whilo,
  output logic [DATA_W-1:0]     out_hi,
  output logic [DATA_W-1:0]     out_lo,
  output logic [1:0]            occupancy
);

  // --------------------------------------------------------------------------
  // State encoding doubles as the occupancy count.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_in_fire;
  logic w_out_fire;
  logic w_load_head_in;    // head <= incoming payload
  logic w_load_head_skid;  // head <= skid entry
  logic w_load_skid;       // skid <= incoming payload

  // GPR payload storage
  logic [NWB-1:0]        r_head_wreg;
  logic [NWB*ADDR_W-1:0] r_head_waddr;
  logic [NWB*DATA_W-1:0] r_head_wdata;
  logic [NWB-1:0]        r_skid_wreg;
  logic [NWB*ADDR_W-1:0] r_skid_waddr;
  logic [NWB*DATA_W-1:0] r_skid_wdata;

  // Write enables after r0 suppression
  logic [NWB-1:0]        w_cap_wreg;

  // --------------------------------------------------------------------------
  // Handshake decode: both ready and valid come from registered state only,
  // so there is no combinational path from out_ready to in_ready nor from
  // any input to any output.
  // --------------------------------------------------------------------------
  assign in_ready   = (r_state != ST_TWO);
  assign out_valid  = (r_state != ST_EMPTY);
  assign occupancy  = r_state;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // --------------------------------------------------------------------------
  // Next-state and load-select logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt    = ST_ONE;
          w_load_head_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          // Head drains while a new entry replaces it in the same cycle.
          w_load_head_in = 1'b1;
        end else if (w_in_fire) begin
          // Head is stalled; the in-flight transfer lands in the skid slot.
          w_state_nxt = ST_TWO;
          w_load_skid = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so in_valid is ignored.
        if (w_out_fire) begin
          w_state_nxt      = ST_ONE;
          w_load_head_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // r0 suppression on capture: the enable is dropped, address/data are kept.
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < NWB; k++) begin : g_r0_sup
      assign w_cap_wreg[k] = in_wreg[k] &
                             (in_waddr[k*ADDR_W +: ADDR_W] != '0);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // GPR write enables: flush clears them so no stale enable can survive.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head_wreg <= '0;
      r_skid_wreg <= '0;
    end else if (flush) begin
      r_head_wreg <= '0;
      r_skid_wreg <= '0;
    end else begin
      if (w_load_head_in) begin
        r_head_wreg <= w_cap_wreg;
      end else if (w_load_head_skid) begin
        r_head_wreg <= r_skid_wreg;
      end
      if (w_load_skid) begin
        r_skid_wreg <= w_cap_wreg;
      end
    end
  end

  // GPR address/data: held through flush so the bubble outputs stay stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head_waddr <= '0;
      r_head_wdata <= '0;
      r_skid_waddr <= '0;
      r_skid_wdata <= '0;
    end else if (!flush) begin
      if (w_load_head_in) begin
        r_head_waddr <= in_waddr;
        r_head_wdata <= in_wdata;
      end else if (w_load_head_skid) begin
        r_head_waddr <= r_skid_waddr;
        r_head_wdata <= r_skid_wdata;
      end
      if (w_load_skid) begin
        r_skid_waddr <= in_waddr;
        r_skid_wdata <= in_wdata;
      end
    end
  end

  // Enables are gated by out_valid so a bubble never writes back.
  assign out_wreg  = r_head_wreg & {NWB{out_valid}};
  assign out_waddr = r_head_waddr;
  assign out_wdata = r_head_wdata;

  // --------------------------------------------------------------------------
  // Optional HI/LO channel
  // --------------------------------------------------------------------------
  generate
    if (HILO_EN != 0) begin : g_hilo
      logic              r_head_whilo;
      logic [DATA_W-1:0] r_head_hi;
      logic [DATA_W-1:0] r_head_lo;
      logic              r_skid_whilo;
      logic [DATA_W-1:0] r_skid_hi;
      logic [DATA_W-1:0] r_skid_lo;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_head_whilo <= 1'b0;
          r_skid_whilo <= 1'b0;
        end else if (flush) begin
          r_head_whilo <= 1'b0;
          r_skid_whilo <= 1'b0;
        end else begin
          if (w_load_head_in) begin
            r_head_whilo <= in_whilo;
          end else if (w_load_head_skid) begin
            r_head_whilo <= r_skid_whilo;
          end
          if (w_load_skid) begin
            r_skid_whilo <= in_whilo;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_head_hi <= '0;
          r_head_lo <= '0;
          r_skid_hi <= '0;
          r_skid_lo <= '0;
        end else if (!flush) begin
          if (w_load_head_in) begin
            r_head_hi <= in_hi;
            r_head_lo <= in_lo;
          end else if (w_load_head_skid) begin
            r_head_hi <= r_skid_hi;
            r_head_lo <= r_skid_lo;
          end
          if (w_load_skid) begin
            r_skid_hi <= in_hi;
            r_skid_lo <= in_lo;
          end
        end
      end

      assign out_whilo = r_head_whilo & out_valid;
      assign out_hi    = r_head_hi;
      assign out_lo    = r_head_lo;
    end else begin : g_no_hilo
      // HI/LO inputs are deliberately ignored in this configuration.
      logic w_hilo_unused;
      assign w_hilo_unused = ^{in_whilo, in_hi, in_lo};

      assign out_whilo = 1'b0;
      assign out_hi    = '0;
      assign out_lo    = '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_skid.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_skid
// Purpose  : Directed self-checking bench for mem_wb_skid. Instance "dut"
//            uses NWB=2, HILO_EN=1; instance "dut_b" uses NWB=1, HILO_EN=0
//            and shares the port-0 stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_skid;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_wreg;
  logic [9:0]  in_waddr;
  logic [63:0] in_wdata;
  logic        in_whilo;
  logic [31:0] in_hi;
  logic [31:0] in_lo;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_wreg;
  logic [9:0]  out_waddr;
  logic [63:0] out_wdata;
  logic        out_whilo;
  logic [31:0] out_hi;
  logic [31:0] out_lo;
  logic [1:0]  occupancy;

  logic        b_in_ready;
  logic        b_out_valid;
  logic [0:0]  b_out_wreg;
  logic [4:0]  b_out_waddr;
  logic [31:0] b_out_wdata;
  logic        b_out_whilo;
  logic [31:0] b_out_hi;
  logic [31:0] b_out_lo;
  logic [1:0]  b_occupancy;

  int checks;
  int errors;

  mem_wb_skid #(.DATA_W(32), .ADDR_W(5), .NWB(2), .HILO_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_wreg   (in_wreg),
    .in_waddr  (in_waddr),
    .in_wdata  (in_wdata),
    .in_whilo  (in_whilo),
    .in_hi     (in_hi),
    .in_lo     (in_lo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_wreg  (out_wreg),
    .out_waddr (out_waddr),
    .out_wdata (out_wdata),
    .out_whilo (out_whilo),
    .out_hi    (out_hi),
    .out_lo    (out_lo),
    .occupancy (occupancy)
  );

  mem_wb_skid #(.DATA_W(32), .ADDR_W(5), .NWB(1), .HILO_EN(0)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (b_in_ready),
    .in_wreg   (in_wreg[0:0]),
    .in_waddr  (in_waddr[4:0]),
    .in_wdata  (in_wdata[31:0]),
    .in_whilo  (in_whilo),
    .in_hi     (in_hi),
    .in_lo     (in_lo),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .out_wreg  (b_out_wreg),
    .out_waddr (b_out_waddr),
    .out_wdata (b_out_wdata),
    .out_whilo (b_out_whilo),
    .out_hi    (b_out_hi),
    .out_lo    (b_out_lo),
    .occupancy (b_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a single-port (port 0) instruction.
  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
    in_valid = v;
    in_wreg  = 2'b01;
    in_waddr = {5'd0, a};
    in_wdata = {32'd0, d};
    in_whilo = 1'b0;
    in_hi    = 32'd0;
    in_lo    = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_wreg = 2'b11; in_waddr = {5'd2, 5'd1};
    in_wdata = 64'h1111_2222_3333_4444; in_whilo = 1'b1;
    in_hi = 32'h5; in_lo = 32'h6;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_wreg !== 2'b00) begin errors++; $display("FAIL reset_out_wreg: got %b want 00", out_wreg); end
    checks++;
    if (out_wdata !== 64'd0) begin errors++; $display("FAIL reset_out_wdata: got %h want 0", out_wdata); end
    checks++;
    if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++;
    if ({out_whilo, out_hi, out_lo} !== 65'd0) begin errors++; $display("FAIL reset_hilo: got %b %h %h want 0", out_whilo, out_hi, out_lo); end
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0);
    step();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'(i), 32'h100 + 32'(i));
      step();
      checks++;
      if (out_valid !== 1'b1 || out_waddr[4:0] !== 5'(i) || out_wdata[31:0] !== 32'h100 + 32'(i)
          || out_wreg !== 2'b01) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b a=%0d d=%h we=%b want v=1 a=%0d d=%h we=01",
                 i, out_valid, out_waddr[4:0], out_wdata[31:0], out_wreg, i, 32'h100 + 32'(i));
      end
      checks++;
      if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_occ_%0d: got occ=%0d rdy=%b want occ=1 rdy=1", i, occupancy, in_ready);
      end
    end
    drive(1'b0, 5'd0, 32'd0);
    step();
    checks++;
    if (out_valid !== 1'b0 || out_wreg !== 2'b00 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL stream_drain: got v=%b we=%b occ=%0d want v=0 we=00 occ=0", out_valid, out_wreg, occupancy);
    end
    checks++;
    if (out_wdata[31:0] !== 32'h108 || out_waddr[4:0] !== 5'd8) begin
      errors++;
      $display("FAIL stream_bubble_stable: got a=%0d d=%h want a=8 d=108", out_waddr[4:0], out_wdata[31:0]);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 5'd3, 32'hAAAA);
    step();
    checks++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_wdata[31:0] !== 32'hAAAA) begin
      errors++;
      $display("FAIL bp_after_A: got occ=%0d rdy=%b d=%h want occ=1 rdy=1 d=aaaa", occupancy, in_ready, out_wdata[31:0]);
    end
    drive(1'b1, 5'd4, 32'hBBBB);
    step();
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_wdata[31:0] !== 32'hAAAA || out_waddr[4:0] !== 5'd3) begin
      errors++;
      $display("FAIL bp_after_B: got occ=%0d rdy=%b a=%0d d=%h want occ=2 rdy=0 a=3 d=aaaa",
               occupancy, in_ready, out_waddr[4:0], out_wdata[31:0]);
    end
    drive(1'b1, 5'd5, 32'hCCCC);
    step();
    step();
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_wdata[31:0] !== 32'hAAAA) begin
      errors++;
      $display("FAIL bp_C_held: got occ=%0d rdy=%b d=%h want occ=2 rdy=0 d=aaaa", occupancy, in_ready, out_wdata[31:0]);
    end
    checks++;
    if (b_occupancy !== 2'd2 || b_out_wdata !== 32'hAAAA) begin
      errors++;
      $display("FAIL bp_b_held: got occ=%0d d=%h want occ=2 d=aaaa", b_occupancy, b_out_wdata);
    end
    // A is consumed at this edge; B moves to head, C still refused.
    out_ready = 1'b1;
    step();
    checks++;
    if (occupancy !== 2'd1 || out_wdata[31:0] !== 32'hBBBB || out_waddr[4:0] !== 5'd4 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_deliver_B: got occ=%0d a=%0d d=%h rdy=%b want occ=1 a=4 d=bbbb rdy=1",
               occupancy, out_waddr[4:0], out_wdata[31:0], in_ready);
    end
    // B consumed, C accepted in the same edge.
    step();
    checks++;
    if (occupancy !== 2'd1 || out_wdata[31:0] !== 32'hCCCC || out_waddr[4:0] !== 5'd5) begin
      errors++;
      $display("FAIL bp_deliver_C: got occ=%0d a=%0d d=%h want occ=1 a=5 d=cccc",
               occupancy, out_waddr[4:0], out_wdata[31:0]);
    end
    drive(1'b0, 5'd0, 32'd0);
    step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL bp_drain: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 5'd9, 32'hD1);
    step();
    drive(1'b1, 5'd10, 32'hE1);
    step();
    checks++;
    if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_prefill: got occ=%0d want 2", occupancy); end
    flush = 1'b1;
    drive(1'b1, 5'd11, 32'hF1);
    step();
    flush = 1'b0;
    drive(1'b0, 5'd0, 32'd0);
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_wreg !== 2'b00) begin
      errors++;
      $display("FAIL flush_full: got occ=%0d v=%b rdy=%b we=%b want occ=0 v=0 rdy=1 we=00",
               occupancy, out_valid, in_ready, out_wreg);
    end
    checks++;
    if (b_occupancy !== 2'd0 || b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_full_b: got occ=%0d v=%b want occ=0 v=0", b_occupancy, b_out_valid);
    end
    // Flush while in ONE with an input accepted in the same cycle.
    drive(1'b1, 5'd12, 32'h12);
    step();
    flush = 1'b1;
    drive(1'b1, 5'd13, 32'h13);
    step();
    flush = 1'b0;
    drive(1'b0, 5'd0, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
        errors++;
        $display("FAIL flush_no_ghost_%0d: got v=%b occ=%0d want v=0 occ=0", i, out_valid, occupancy);
      end
    end
    drive(1'b1, 5'd14, 32'h77);
    step();
    drive(1'b0, 5'd0, 32'd0);
    checks++;
    if (out_valid !== 1'b1 || out_wdata[31:0] !== 32'h77 || out_waddr[4:0] !== 5'd14 || out_wreg !== 2'b01) begin
      errors++;
      $display("FAIL flush_recover: got v=%b a=%0d d=%h we=%b want v=1 a=14 d=77 we=01",
               out_valid, out_waddr[4:0], out_wdata[31:0], out_wreg);
    end
    step();
  endtask

  task automatic test_r0_suppress();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_wreg   = 2'b11;
    in_waddr  = {5'd7, 5'd0};
    in_wdata  = {32'hDEADBEEF, 32'h1234};
    in_whilo  = 1'b0;
    step();
    drive(1'b0, 5'd0, 32'd0);
    checks++;
    if (out_wreg !== 2'b10) begin errors++; $display("FAIL r0_wreg: got %b want 10", out_wreg); end
    checks++;
    if (out_waddr !== {5'd7, 5'd0} || out_wdata !== {32'hDEADBEEF, 32'h1234}) begin
      errors++;
      $display("FAIL r0_payload: got a=%h d=%h want a=%h d=%h", out_waddr, out_wdata,
               {5'd7, 5'd0}, {32'hDEADBEEF, 32'h1234});
    end
    checks++;
    if (b_out_valid !== 1'b1 || b_out_wreg !== 1'b0 || b_out_wdata !== 32'h1234) begin
      errors++;
      $display("FAIL r0_b: got v=%b we=%b d=%h want v=1 we=0 d=1234", b_out_valid, b_out_wreg, b_out_wdata);
    end
    step();
  endtask

  task automatic test_hilo();
    out_ready = 1'b0;
    drive(1'b1, 5'd6, 32'h66);
    in_whilo = 1'b1;
    in_hi    = 32'h1;
    in_lo    = 32'hFFFFFFFF;
    step();
    drive(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_whilo !== 1'b1 || out_hi !== 32'h1 || out_lo !== 32'hFFFFFFFF || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hilo_stall_%0d: got v=%b w=%b hi=%h lo=%h want v=1 w=1 hi=1 lo=ffffffff",
                 i, out_valid, out_whilo, out_hi, out_lo);
      end
      checks++;
      if (b_out_whilo !== 1'b0 || b_out_hi !== 32'd0 || b_out_lo !== 32'd0) begin
        errors++;
        $display("FAIL hilo_off_%0d: got w=%b hi=%h lo=%h want 0", i, b_out_whilo, b_out_hi, b_out_lo);
      end
      if (i < 2) step();
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_whilo !== 1'b0 || out_hi !== 32'h1 || out_lo !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL hilo_after_fire: got v=%b w=%b hi=%h lo=%h want v=0 w=0 hi=1 lo=ffffffff",
               out_valid, out_whilo, out_hi, out_lo);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_r0_suppress();
    test_hilo();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
